// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared types and lane mapping for the data-store arbiter
package ds_pkg;

    localparam int NCORES = 4;

    localparam logic [1:0] LANE_HI   = 2'd0;
    localparam logic [1:0] LANE_MH   = 2'd1;
    localparam logic [1:0] LANE_ML   = 2'd2;
    localparam logic [1:0] LANE_LO   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ds_state_e;

    // Lane 0 is the most significant halfword of the row, same as the load mux.
    function automatic int lane_lsb(input logic [1:0] lane);
        return 48 - 16 * int'(lane);
    endfunction

endpackage

// File: rtl/ds_lane_place.sv
// rtl/ds_lane_place.sv - places one 16-bit store word into its 64-bit row lane
module ds_lane_place
    import ds_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [15:0] din,
    output logic [63:0] row_data,
    output logic [3:0]  lane_en
);

    always_comb begin
        row_data = 64'(din) << lane_lsb(lane);
        lane_en  = 4'b1000 >> lane;
    end

endmodule

// File: rtl/ds_arbiter.sv
// rtl/ds_arbiter.sv - round-robin, row-merging store arbiter for four cores
module ds_arbiter
    import ds_pkg::*;
#(
    parameter int WRITE_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        MW1,
    input  logic        MW2,
    input  logic        MW3,
    input  logic        MW4,
    input  logic [15:0] MADDR1,
    input  logic [15:0] MADDR2,
    input  logic [15:0] MADDR3,
    input  logic [15:0] MADDR4,
    input  logic [15:0] DIN1,
    input  logic [15:0] DIN2,
    input  logic [15:0] DIN3,
    input  logic [15:0] DIN4,
    output logic        MEMWRITE,
    output logic [15:0] MEMADDR,
    output logic [63:0] MEMDATA,
    output logic [3:0]  MEMLANE,
    output logic        ACK1,
    output logic        ACK2,
    output logic        ACK3,
    output logic        ACK4
);

    localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WRITE_CYCLES - 1);

    logic [3:0]  mw;
    logic [15:0] maddr       [NCORES];
    logic [15:0] din         [NCORES];
    logic [63:0] placed_data [NCORES];
    logic [3:0]  placed_en   [NCORES];

    assign mw       = {MW4, MW3, MW2, MW1};
    assign maddr[0] = MADDR1;
    assign maddr[1] = MADDR2;
    assign maddr[2] = MADDR3;
    assign maddr[3] = MADDR4;
    assign din[0]   = DIN1;
    assign din[1]   = DIN2;
    assign din[2]   = DIN3;
    assign din[3]   = DIN4;

    for (genvar i = 0; i < NCORES; i++) begin : g_place
        ds_lane_place u_place (
            .lane     (maddr[i][1:0]),
            .din      (din[i]),
            .row_data (placed_data[i]),
            .lane_en  (placed_en[i])
        );
    end

    ds_state_e   state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        memwrite_q, memwrite_d;
    logic [15:0] memaddr_q, memaddr_d;
    logic [63:0] memdata_q, memdata_d;
    logic [3:0]  memlane_q, memlane_d;
    logic [3:0]  serve_q, serve_d;
    logic [3:0]  ack_q, ack_d;

    logic [1:0]  win, idx;
    logic        found;
    logic [3:0]  serve, claimed;
    logic [63:0] mdata;

    // Descending scan so the requester nearest ptr is assigned last and wins.
    always_comb begin
        win     = ptr_q;
        found   = 1'b0;
        idx     = '0;
        serve   = '0;
        claimed = '0;
        mdata   = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (mw[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        for (int k = 0; k < NCORES; k++) begin
            idx = win + 2'(k);
            if (mw[idx] && (maddr[idx][15:2] == maddr[win][15:2])
                    && ((claimed & placed_en[idx]) == 4'b0000)) begin
                serve[idx] = 1'b1;
                claimed    = claimed | placed_en[idx];
                mdata      = mdata | placed_data[idx];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        memwrite_d = memwrite_q;
        memaddr_d  = memaddr_q;
        memdata_d  = memdata_q;
        memlane_d  = memlane_q;
        serve_d    = serve_q;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = WRITE;
                    win_d      = win;
                    cnt_d      = '0;
                    memwrite_d = 1'b1;
                    memaddr_d  = {2'b00, maddr[win][15:2]};
                    memdata_d  = mdata;
                    memlane_d  = claimed;
                    serve_d    = serve;
                end
            end
            WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    memwrite_d = 1'b0;
                    ack_d      = serve_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = win_q + 2'd1;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            memwrite_q <= 1'b0;
            memaddr_q  <= '0;
            memdata_q  <= '0;
            memlane_q  <= '0;
            serve_q    <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            memwrite_q <= memwrite_d;
            memaddr_q  <= memaddr_d;
            memdata_q  <= memdata_d;
            memlane_q  <= memlane_d;
            serve_q    <= serve_d;
            ack_q      <= ack_d;
        end
    end

    assign MEMWRITE = memwrite_q;
    assign MEMADDR  = memaddr_q;
    assign MEMDATA  = memdata_q;
    assign MEMLANE  = memlane_q;
    assign ACK1     = ack_q[0];
    assign ACK2     = ack_q[1];
    assign ACK3     = ack_q[2];
    assign ACK4     = ack_q[3];

endmodule

// File: doc/ds_arbiter.md
# ds_arbiter

Store-side counterpart of the data-load controller. It shares the single 64-bit-row data memory write port between four cores, each issuing 16-bit word stores. It arbitrates round-robin and merges requests that hit the same row in distinct lanes into one row write. Each served core receives a one-cycle acknowledge. The block sits between the core MW/MADDR/DIN store buses and the data memory write port.

## Interface
- WRITE_CYCLES, 1, number of consecutive cycles MEMWRITE is held per row write (memory write latency, ≥1)
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  reset, synchronous, active-low
- MW1..MW4  input  1 each  store request from core i; held until ACKi
- MADDR1..MADDR4  input  16 each  word address of core i; [15:2] row, [1:0] lane
- DIN1..DIN4  input  16 each  store data of core i
- MEMWRITE  output  1  write strobe to data memory
- MEMADDR  output  16  row address, {2'b0, row[13:0]}
- MEMDATA  output  64  row write data; unused lanes 0
- MEMLANE  output  4  lane write enables; bit3→[63:48], bit2→[47:32], bit1→[31:16], bit0→[15:0]
- ACK1..ACK4  output  1 each  one-cycle pulse: core i store committed

## Operation
- Lane mapping matches the load path: MADDR[1:0]=0→[63:48], 1→[47:32], 2→[31:16], 3→[15:0].
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - If no MWi is high, stay in IDLE.
  - Otherwise, the winner is the first requester in round-robin order starting at ptr (2-bit, 0=core1).
  - Latch the winner's row.
  - Build the served set:
    - The winner, plus every other requester with the same row.
    - Candidates are visited in round-robin order from the winner.
    - A candidate joins only if its lane is not yet claimed.
  - Latch MEMDATA, MEMLANE and the served mask, then go to WRITE.
- WRITE:
  - MEMWRITE=1 and MEMADDR/MEMDATA/MEMLANE are stable.
  - A counter counts WRITE_CYCLES cycles, then the FSM goes to DONE.
- DONE:
  - MEMWRITE=0.
  - ACKi=1 for each core in the served mask.
  - ptr ← winner+1 (mod 4), then IDLE.
- Deferred requesters (different row, or same-word collision) keep MW high and are arbitrated again in a later IDLE.
- Core obligations:
  - Hold MWi, MADDRi and DINi stable from assertion until ACKi is sampled.
  - Deassert MWi in the cycle following ACKi.
- Request changes during WRITE/DONE are ignored. The latched values are used.
- Reset (rstn=0 at an edge), from any state including mid-WRITE:
  - state=IDLE, ptr=0, counter=0.
  - MEMWRITE=0, MEMADDR=0, MEMDATA=0, MEMLANE=0, all ACK=0.
  - The interrupted write is dropped without ACK. The core re-arbitrates after reset.

## Timing
- All outputs are registered. Reset values are all 0.
- A request high at IDLE edge t gives:
  - MEMWRITE high in cycles t+1 … t+WRITE_CYCLES.
  - ACK in cycle t+WRITE_CYCLES+1.
  - IDLE again in cycle t+WRITE_CYCLES+2.
- Throughput: one row write per WRITE_CYCLES+2 cycles. There is no back-to-back WRITE.
- ACKs of one merged group are simultaneous.
- Worst-case wait for any core is 4 transactions.

## Structure
- Package ds_pkg:
  - State enum {IDLE, WRITE, DONE}.
  - Lane index constants and the lane→bit-slice mapping, shared with the load MUX.
  - NCORES=4.
- Sub-module ds_lane_place: combinational; places a 16-bit word into its 64-bit lane slot and produces the one-hot lane enable from MADDR[1:0]. Instantiated four times.
- Round-robin selection and merge logic stay inline in ds_arbiter.

## Test plan
- Single store: MW2=1, MADDR2=0x0011, DIN2=0xBEEF → MEMADDR=0x0004, MEMLANE=0100, MEMDATA=0x0000_BEEF_0000_0000 for 1 cycle; ACK2 pulse 2 cycles after request.
- Round-robin: all four MW high, rows 1,2,3,4, ptr=0 → served in order core1,2,3,4; repeated with ptr=2 after reset+one write → order 3,4,1,2.
- Merge: core1 0x0020, core3 0x0023, core4 0x0021, same row 8 → one write, MEMLANE=1101, MEMADDR=0x0008, ACK1/ACK3/ACK4 same cycle.
- Same-word collision: core1 and core2 both 0x0040, ptr=1 → core2 written first (MEMLANE=1000, DIN2); core1 written in the next transaction.
- WRITE_CYCLES=3: MEMWRITE high exactly 3 consecutive cycles, outputs stable, ACK in the 4th cycle; changing DIN mid-write does not alter MEMDATA.
- Reset mid-WRITE: rstn=0 during the 2nd write cycle → next cycle all outputs 0, no ACK; after release, the held request is rewritten from scratch with ptr=0.
